// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcode/funct
// encodings, ALU and PC operation codes, FSM states, trap causes and the
// instruction classes produced by ctrl_decode.
package cpu_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operations
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    // Program counter operations
    localparam logic [2:0] PC_HOLD   = 3'd0;
    localparam logic [2:0] PC_INC    = 3'd1;
    localparam logic [2:0] PC_JMP    = 3'd2;
    localparam logic [2:0] PC_BRANCH = 3'd3;
    localparam logic [2:0] PC_JR     = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_IMEM    = 2'd2,
        CAUSE_DMEM    = 2'd3
    } cause_e;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_JR,
        CLS_J,
        CLS_LW,
        CLS_SW,
        CLS_ADDI,
        CLS_BEQ,
        CLS_BNE,
        CLS_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: latched opcode/funct to instruction
// class, ALU operation and illegal-instruction flag.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_e    iclass_o,
    output logic [3:0] alu_op_o,
    output logic       illegal_o
);

    // Map opcode/funct to class and ALU op; unknown encodings stay illegal
    always_comb begin
        iclass_o = CLS_ILLEGAL;
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD: begin iclass_o = CLS_RTYPE; alu_op_o = ALU_ADD; end
                    FN_SUB: begin iclass_o = CLS_RTYPE; alu_op_o = ALU_SUB; end
                    FN_AND: begin iclass_o = CLS_RTYPE; alu_op_o = ALU_AND; end
                    FN_OR:  begin iclass_o = CLS_RTYPE; alu_op_o = ALU_OR;  end
                    FN_SLT: begin iclass_o = CLS_RTYPE; alu_op_o = ALU_SLT; end
                    FN_JR:  iclass_o = CLS_JR;
                    default: ;
                endcase
            end
            OP_J:    iclass_o = CLS_J;
            OP_BEQ:  begin iclass_o = CLS_BEQ; alu_op_o = ALU_SUB; end
            OP_BNE:  begin iclass_o = CLS_BNE; alu_op_o = ALU_SUB; end
            OP_ADDI: iclass_o = CLS_ADDI;
            OP_LW:   iclass_o = CLS_LW;
            OP_SW:   iclass_o = CLS_SW;
            default: ;
        endcase
    end

    assign illegal_o = (iclass_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: latches one instruction per fetch and issues
// one datapath phase per cycle (FETCH/DECODE/EXEC/MEM/WB), trapping on illegal
// opcodes and memory ready timeouts. Define MULTICYCLE_CTRL_PERF_EN to build
// the cycle / retired-instruction performance counters.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_eflags_zf,
    output logic        ir_wren,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        signal_data_mem_wren,
    output logic        signal_reg_file_wren,
    output logic        signal_reg_file_dmux_sel,
    output logic        signal_reg_file_rmux_sel,
    output logic        signal_alu_mux_sel,
    output logic [3:0]  signal_alu_control,
    output logic [2:0]  signal_pc_control,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired
);

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [5:0]        op_q, op_d;
    logic [5:0]        funct_q, funct_d;

    iclass_e           iclass;
    logic [3:0]        alu_op;
    logic              illegal;
    logic              wait_hit;
    logic              is_mem_op;
    logic              instr_unused;

    assign instr_unused = ^instr[25:6];

    ctrl_decode u_decode (
        .opcode_i  (op_q),
        .funct_i   (funct_q),
        .iclass_o  (iclass),
        .alu_op_o  (alu_op),
        .illegal_o (illegal)
    );

    // The request that is pending this cycle is its WAIT_MAX-th unanswered one
    assign wait_hit  = (wait_q == WAIT_W'(WAIT_MAX - 1));
    assign is_mem_op = (iclass == CLS_LW) || (iclass == CLS_SW) || (iclass == CLS_ADDI);

    // State register plus latched instruction fields, wait counter and cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
            wait_q  <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    // Next-state logic; wait counter defaults to 0 so it is clear on entry to FETCH/MEM
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wait_d  = '0;
        op_d    = op_q;
        funct_d = funct_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    op_d    = instr[31:26];
                    funct_d = instr[5:0];
                    state_d = ST_DECODE;
                end else if (wait_hit) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (iclass == CLS_J || iclass == CLS_JR) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (iclass)
                    CLS_BEQ, CLS_BNE: state_d = ST_FETCH;
                    CLS_LW, CLS_SW:   state_d = ST_MEM;
                    default:          state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = (iclass == CLS_LW) ? ST_WB : ST_FETCH;
                end else if (wait_hit) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath controls decoded from the state; everything forced low during reset
    always_comb begin
        ir_wren                  = 1'b0;
        imem_req                 = 1'b0;
        dmem_req                 = 1'b0;
        signal_data_mem_wren     = 1'b0;
        signal_reg_file_wren     = 1'b0;
        signal_reg_file_dmux_sel = 1'b0;
        signal_reg_file_rmux_sel = 1'b0;
        signal_alu_mux_sel       = 1'b0;
        signal_alu_control       = ALU_ADD;
        signal_pc_control        = PC_HOLD;
        trap                     = 1'b0;
        trap_cause               = CAUSE_NONE;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_wren  = imem_ready;
                end
                ST_DECODE: begin
                    if (iclass == CLS_J)  signal_pc_control = PC_JMP;
                    if (iclass == CLS_JR) signal_pc_control = PC_JR;
                end
                ST_EXEC: begin
                    signal_alu_control = alu_op;
                    signal_alu_mux_sel = is_mem_op;
                    if (iclass == CLS_BEQ)
                        signal_pc_control = alu_eflags_zf ? PC_BRANCH : PC_INC;
                    if (iclass == CLS_BNE)
                        signal_pc_control = alu_eflags_zf ? PC_INC : PC_BRANCH;
                end
                ST_MEM: begin
                    dmem_req             = 1'b1;
                    signal_data_mem_wren = (iclass == CLS_SW);
                    signal_alu_control   = alu_op;
                    signal_alu_mux_sel   = is_mem_op;
                    if (dmem_ready && iclass == CLS_SW) signal_pc_control = PC_INC;
                end
                ST_WB: begin
                    // ALU controls stay on so the ALU result remains valid as write data
                    signal_alu_control       = alu_op;
                    signal_alu_mux_sel       = is_mem_op;
                    signal_reg_file_wren     = 1'b1;
                    signal_reg_file_dmux_sel = (iclass == CLS_LW);
                    signal_reg_file_rmux_sel = (iclass == CLS_RTYPE);
                    signal_pc_control        = PC_INC;
                end
                ST_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] retired_q, retired_d;

    assign cycles_d  = (state_q != ST_TRAP) ? cycles_q + 32'd1 : cycles_q;
    assign retired_d = (signal_pc_control != PC_HOLD) ? retired_q + 32'd1 : retired_q;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q  <= '0;
            retired_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            retired_q <= retired_d;
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_retired = retired_q;
`else
    assign perf_cycles  = '0;
    assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle control vector checks
// against hand-computed expectations for each instruction class, traps,
// timeouts and reset abort.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        alu_eflags_zf = 1'b0;
    logic        ir_wren, imem_req, dmem_req;
    logic        signal_data_mem_wren, signal_reg_file_wren;
    logic        signal_reg_file_dmux_sel, signal_reg_file_rmux_sel, signal_alu_mux_sel;
    logic [3:0]  signal_alu_control;
    logic [2:0]  signal_pc_control;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] perf_cycles, perf_retired;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    multicycle_ctrl #(.WAIT_MAX(15), .WAIT_W(4)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .instr                    (instr),
        .imem_ready               (imem_ready),
        .dmem_ready               (dmem_ready),
        .alu_eflags_zf            (alu_eflags_zf),
        .ir_wren                  (ir_wren),
        .imem_req                 (imem_req),
        .dmem_req                 (dmem_req),
        .signal_data_mem_wren     (signal_data_mem_wren),
        .signal_reg_file_wren     (signal_reg_file_wren),
        .signal_reg_file_dmux_sel (signal_reg_file_dmux_sel),
        .signal_reg_file_rmux_sel (signal_reg_file_rmux_sel),
        .signal_alu_mux_sel       (signal_alu_mux_sel),
        .signal_alu_control       (signal_alu_control),
        .signal_pc_control        (signal_pc_control),
        .trap                     (trap),
        .trap_cause               (trap_cause),
        .perf_cycles              (perf_cycles),
        .perf_retired             (perf_retired)
    );

    always #5 clk = ~clk;

    // {ir_wren, imem_req, dmem_req, dmw, rfw, dmux, rmux, amux, alu[3:0], pc[2:0], trap, cause[1:0]}
    logic [17:0] ctl;
    assign ctl = {ir_wren, imem_req, dmem_req, signal_data_mem_wren, signal_reg_file_wren,
                  signal_reg_file_dmux_sel, signal_reg_file_rmux_sel, signal_alu_mux_sel,
                  signal_alu_control, signal_pc_control, trap, trap_cause};

    function automatic logic [17:0] mk(input logic irw, imr, dmr, dmw, rfw, dmx, rmx, amx,
                                       input logic [3:0] alu, input logic [2:0] pc,
                                       input logic tr, input logic [1:0] tc);
        return {irw, imr, dmr, dmw, rfw, dmx, rmx, amx, alu, pc, tr, tc};
    endfunction

    localparam logic [17:0] E_IDLE  = 18'd0;
    localparam logic [17:0] E_FETCH = 18'b01_0000_0000_0000_0000;
    localparam logic [17:0] E_IRW   = 18'b11_0000_0000_0000_0000;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'hABCDE, fn};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic ir, input logic dr, input logic z);
        instr = i; imem_ready = ir; dmem_ready = dr; alu_eflags_zf = z;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(enc(OP_RTYPE, FN_ADD), 1'b1, 1'b1, 1'b1);
        cyc(); cyc();
        n_cmp++; if (ctl !== E_IDLE) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", ctl, E_IDLE); end
        n_cmp++; if ({perf_cycles, perf_retired} !== 64'd0) begin n_bad++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_cycles, perf_retired); end
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL reset_fetch: got %h want %h", ctl, E_FETCH); end
    endtask

    task automatic test_illegal();
        logic [17:0] exp;
        drive(enc(6'h3F, 6'h00), 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_IRW) begin n_bad++; $display("FAIL ill_fetch: got %h want %h", ctl, E_IRW); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_IDLE) begin n_bad++; $display("FAIL ill_decode: got %h want %h", ctl, E_IDLE); end
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, PC_HOLD, 1, 2'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(); drive(enc(OP_LW, 6'h0), 1'b1, 1'b1, 1'b1);
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL ill_trap[%0d]: got %h want %h", k, ctl, exp); end
        end
        n_cmp++; if (perf_cycles !== (PERF ? 32'd2 : 32'd0)) begin n_bad++; $display("FAIL ill_perf_cycles: got %0d want %0d", perf_cycles, PERF ? 2 : 0); end
        n_cmp++; if (perf_retired !== 32'd0) begin n_bad++; $display("FAIL ill_perf_retired: got %0d want 0", perf_retired); end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        logic [3:0]  ac [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [17:0] exp;
        for (int k = 0; k < 5; k++) begin
            drive(enc(OP_RTYPE, fn[k]), 1'b1, 1'b0, 1'b0);
            n_cmp++; if (ctl !== E_IRW) begin n_bad++; $display("FAIL rtype_fetch[%0d]: got %h want %h", k, ctl, E_IRW); end
            cyc(); drive(32'h0, 1'b1, 1'b1, 1'b1);
            n_cmp++; if (ctl !== E_IDLE) begin n_bad++; $display("FAIL rtype_decode[%0d]: got %h want %h", k, ctl, E_IDLE); end
            cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
            exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ac[k], PC_HOLD, 0, 2'd0);
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL rtype_exec[%0d]: got %h want %h", k, ctl, exp); end
            cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
            exp = mk(0, 0, 0, 0, 1, 0, 1, 0, ac[k], PC_INC, 0, 2'd0);
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL rtype_wb[%0d]: got %h want %h", k, ctl, exp); end
            cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL rtype_refetch[%0d]: got %h want %h", k, ctl, E_FETCH); end
        end
    endtask

    task automatic test_addi();
        logic [17:0] exp;
        drive(enc(OP_ADDI, 6'h3F), 1'b1, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 1, ALU_ADD, PC_HOLD, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL addi_exec: got %h want %h", ctl, exp); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp = mk(0, 0, 0, 0, 1, 0, 0, 1, ALU_ADD, PC_INC, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL addi_wb: got %h want %h", ctl, exp); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lw();
        logic [17:0] exp;
        drive(enc(OP_LW, 6'h00), 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_IRW) begin n_bad++; $display("FAIL lw_fetch: got %h want %h", ctl, E_IRW); end
        cyc(); drive(32'h0, 1'b1, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b1, 1'b0);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 1, ALU_ADD, PC_HOLD, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL lw_exec: got %h want %h", ctl, exp); end
        exp = mk(0, 0, 1, 0, 0, 0, 0, 1, ALU_ADD, PC_HOLD, 0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); drive(32'h0, 1'b0, (k == 3), 1'b0);
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL lw_mem[%0d]: got %h want %h", k, ctl, exp); end
        end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp = mk(0, 0, 0, 0, 1, 1, 0, 1, ALU_ADD, PC_INC, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL lw_wb: got %h want %h", ctl, exp); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL lw_refetch: got %h want %h", ctl, E_FETCH); end
    endtask

    task automatic test_sw();
        logic [17:0] exp;
        drive(enc(OP_SW, 6'h00), 1'b1, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b1, 1'b0);
        exp = mk(0, 0, 1, 1, 0, 0, 0, 1, ALU_ADD, PC_INC, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL sw_mem: got %h want %h", ctl, exp); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL sw_refetch: got %h want %h", ctl, E_FETCH); end
    endtask

    task automatic test_branch();
        logic [5:0]  op [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic        zf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  pc [4] = '{PC_BRANCH, PC_INC, PC_INC, PC_BRANCH};
        logic [17:0] exp;
        for (int k = 0; k < 4; k++) begin
            drive(enc(op[k], 6'h00), 1'b1, 1'b0, 1'b0);
            cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
            cyc(); drive(32'h0, 1'b0, 1'b0, zf[k]);
            exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ALU_SUB, pc[k], 0, 2'd0);
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL branch_exec[%0d]: got %h want %h", k, ctl, exp); end
            cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL branch_refetch[%0d]: got %h want %h", k, ctl, E_FETCH); end
        end
    endtask

    task automatic test_jump();
        logic [17:0] exp;
        drive(enc(OP_J, 6'h08), 1'b1, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, PC_JMP, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL j_decode: got %h want %h", ctl, exp); end
        cyc(); drive(enc(OP_RTYPE, FN_JR), 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_IRW) begin n_bad++; $display("FAIL jr_fetch: got %h want %h", ctl, E_IRW); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, PC_JR, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL jr_decode: got %h want %h", ctl, exp); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL jr_refetch: got %h want %h", ctl, E_FETCH); end
    endtask

    task automatic test_imem_late();
        logic [17:0] exp;
        for (int k = 1; k <= 15; k++) begin
            drive(enc(OP_J, 6'h00), (k == 15), 1'b0, 1'b0);
            exp = (k == 15) ? E_IRW : E_FETCH;
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL imem_late[%0d]: got %h want %h", k, ctl, exp); end
            cyc();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, PC_JMP, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL imem_late_decode: got %h want %h", ctl, exp); end
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_imem_timeout();
        logic [17:0] exp;
        for (int k = 1; k <= 15; k++) begin
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL imem_wait[%0d]: got %h want %h", k, ctl, E_FETCH); end
            cyc();
        end
        drive(enc(OP_RTYPE, FN_ADD), 1'b1, 1'b1, 1'b0);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, PC_HOLD, 1, 2'd2);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL imem_timeout: got %h want %h", ctl, exp); end
        cyc(); drive(32'h0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL imem_timeout_sticky: got %h want %h", ctl, exp); end
    endtask

    task automatic test_dmem_timeout();
        logic [17:0] exp;
        drive(enc(OP_SW, 6'h00), 1'b1, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        exp = mk(0, 0, 1, 1, 0, 0, 0, 1, ALU_ADD, PC_HOLD, 0, 2'd0);
        for (int k = 1; k <= 15; k++) begin
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL dmem_wait[%0d]: got %h want %h", k, ctl, exp); end
            cyc();
        end
        drive(32'h0, 1'b1, 1'b1, 1'b0);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, PC_HOLD, 1, 2'd3);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL dmem_timeout: got %h want %h", ctl, exp); end
    endtask

    task automatic test_reset_mid_sw();
        logic [17:0] exp;
        drive(enc(OP_J, 6'h00), 1'b1, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc(); drive(enc(OP_SW, 6'h00), 1'b1, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc(); drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp = mk(0, 0, 1, 1, 0, 0, 0, 1, ALU_ADD, PC_HOLD, 0, 2'd0);
        n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL rstmid_mem: got %h want %h", ctl, exp); end
        n_cmp++; if (perf_cycles !== (PERF ? 32'd5 : 32'd0)) begin n_bad++; $display("FAIL rstmid_perf_cycles: got %0d want %0d", perf_cycles, PERF ? 5 : 0); end
        n_cmp++; if (perf_retired !== (PERF ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL rstmid_perf_retired: got %0d want %0d", perf_retired, PERF ? 1 : 0); end
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (ctl !== E_IDLE) begin n_bad++; $display("FAIL rstmid_abort: got %h want %h", ctl, E_IDLE); end
        cyc();
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ctl !== E_FETCH) begin n_bad++; $display("FAIL rstmid_fetch: got %h want %h", ctl, E_FETCH); end
        n_cmp++; if (perf_retired !== 32'd0) begin n_bad++; $display("FAIL rstmid_retired_after: got %0d want 0", perf_retired); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_illegal();
        do_reset();
        test_rtype();
        test_addi();
        test_lw();
        test_sw();
        test_branch();
        test_jump();
        test_imem_late();
        test_imem_timeout();
        do_reset();
        test_dmem_timeout();
        do_reset();
        test_reset_mid_sw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the CPU datapath: program_counter, instruction memory, register file, ALU and data memory.
- Replaces single-cycle decode with an FSM that latches the instruction once and issues one datapath phase per cycle.
- Waits on instruction and data memory ready handshakes; traps on illegal opcodes and on memory timeouts.
- Drives every datapath control signal (signal_* set) from its state register.

Parameters:
WAIT_MAX, 15, max cycles a memory request may wait for ready before bus-error trap
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
instr  input  32  instruction from instruction memory
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
alu_eflags_zf  input  1  ALU zero flag
ir_wren  output  1  datapath instruction-register load pulse
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
signal_data_mem_wren  output  1  data memory write enable
signal_reg_file_wren  output  1  register file write enable
signal_reg_file_dmux_sel  output  1  write data select: 0=ALU, 1=memory
signal_reg_file_rmux_sel  output  1  write address select: 0=rt, 1=rd
signal_alu_mux_sel  output  1  ALU B select: 0=register, 1=sign-extended immediate
signal_alu_control  output  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
signal_pc_control  output  3  PC op: 0 HOLD, 1 INC, 2 JMP, 3 BRANCH, 4 JR
trap  output  1  sticky: controller halted
trap_cause  output  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
perf_cycles  output  32  cycle counter (optional feature)
perf_retired  output  32  retired-instruction counter (optional feature)

Behaviour:
- Reset: asynchronous and active-high. State=FETCH. All outputs 0, pc_control=HOLD, wait counter 0, trap=0.
- Reset mid-instruction aborts immediately. No write enable may be asserted while rst=1.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_wren=1 that cycle; opcode instr[31:26] and funct instr[5:0] latched internally; next state DECODE.
- DECODE: classify the latched opcode/funct.
  - R-type (op 0x00, funct 0x20/0x22/0x24/0x25/0x2A) -> EXEC.
  - jr (op 0, funct 0x08): pc_control=JR -> FETCH.
  - lw 0x23, sw 0x2B, addi 0x08, beq 0x04, bne 0x05 -> EXEC.
  - j 0x02: pc_control=JMP -> FETCH.
  - Anything else -> TRAP, cause 1.
- EXEC:
  - ALU op from funct (R-type), else ADD (lw/sw/addi) or SUB (beq/bne).
  - alu_mux_sel=1 for lw/sw/addi.
  - beq: pc_control = zf ? BRANCH : INC, next FETCH.
  - bne: inverse condition, next FETCH.
  - lw/sw -> MEM; R-type/addi -> WB.
- MEM:
  - dmem_req=1; data_mem_wren=1 only for sw; ALU controls held from EXEC.
  - On dmem_ready: lw -> WB; sw: pc_control=INC -> FETCH.
- WB (exactly one cycle):
  - reg_file_wren=1; dmux_sel=1 for lw; rmux_sel=1 for R-type; pc_control=INC; next FETCH.
- Pulse rules: pc_control is non-HOLD for exactly one cycle per retired instruction; reg_file_wren at most once.
- Latencies with ready on the first request cycle:
  - j/jr: 2 cycles
  - branch: 3 cycles
  - R/addi/sw: 4 cycles
  - lw: 5 cycles
- Wait counter:
  - Clears on entering FETCH or MEM; increments each cycle a request is pending without ready.
  - Reaching WAIT_MAX without ready -> TRAP, cause 2 (FETCH) or 3 (MEM).
  - Ready in the same cycle the counter reaches WAIT_MAX: ready wins.
- imem_ready or dmem_ready while not requested: ignored.
- TRAP: all enables 0, pc_control=HOLD, trap=1; left only by reset.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - perf_cycles increments every non-reset cycle outside TRAP.
  - perf_retired increments on each non-HOLD pc_control cycle.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both outputs tied to 0; no counter flops.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode and funct constants
  - ALU_* codes (4-bit) and PC_* codes (3-bit)
  - state enum
  - trap cause codes
- Sub-module ctrl_decode: combinational; latched opcode/funct -> instruction class, ALU op, illegal flag.

Test Plan:
- add (op 0, funct 0x20), imem_ready at once -> ir_wren cycle 1, EXEC alu_control=0, WB reg_file_wren=1, rmux_sel=1, pc_control=INC; 4 cycles total.
- lw 0x23 with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, then WB dmux_sel=1, rmux_sel=0, wren=1 for one cycle.
- beq with zf=1 -> pc_control=BRANCH in cycle 3; with zf=0 -> INC; reg_file_wren never asserted.
- Opcode 0x3F -> trap=1, cause=1 after DECODE; all enables stay 0 until rst.
- imem_ready held 0 for 15 cycles -> trap, cause=2; ready arriving on cycle 15 -> no trap.
- Assert rst during MEM of sw -> data_mem_wren drops same cycle, state FETCH, perf_retired unchanged (feature on).
